crp16_alu_seq: RTL and testbench
================================

// Module: crp16_alu_seq
// PURPOSE
//  Width-parametrised, multi-cycle successor to the CRP16 single-cycle ALU. Executes the
//  8 base ops plus carry-chained add/sub and iterative multiply/divide. Sits between decode
//  and writeback. Valid/ready handshake on both sides; result and flags held in output regs.
// PARAMETERS
//  WIDTH  16  operand/result width; power of two, >= 8. SHW = $clog2(WIDTH) is derived.
// PORTS
//  clk        in   1      rising-edge clock
//  resetn     in   1      asynchronous, active-low reset
//  in_valid   in   1      operation request
//  in_ready   out  1      unit can accept a request this cycle
//  x, y       in   WIDTH  operands
//  select     in   4      opcode (see BEHAVIOUR)
//  out_valid  out  1      alu_out/flags hold a completed result
//  out_ready  in   1      consumer takes result this cycle
//  alu_out    out  WIDTH  registered result
//  v, c, n, z out  1      registered overflow, carry, negative, zero flags
// BEHAVIOUR
//  Opcodes: 0 LSR, 1 ASR, 2 LSL (shift amount = y[SHW-1:0]), 3 AND, 4 OR, 5 XOR,
//   6 ADD, 7 SUB (x + ~y + 1), 8 ADC (x + y + c), 9 SBC (x + ~y + c),
//   10 MUL (low WIDTH bits, unsigned), 11 MULH (high WIDTH bits, unsigned), 12 DIVU, 13 REMU,
//   14-15 reserved.
//  Flags: n = alu_out[WIDTH-1]; z = (alu_out == 0).
//   Add/sub family: c = carry out of bit WIDTH-1. v = signed overflow, per the CRP16 rules.
//   ADC/SBC use the c register as it stands when the request is accepted.
//   Logic/shift: c = v = 0.
//   MUL: c = v = (high half != 0). MULH: c = v = 0.
//   DIVU/REMU: c = 0, v = divide-by-zero.
//  Reset (async, resetn = 0): state = IDLE, out_valid = 0, alu_out = 0, v = c = n = z = 0,
//   and any in-flight operation is discarded.
//  Accept: in_valid & in_ready. in_ready = (state == IDLE) & (~out_valid | out_ready).
//  FSM states: IDLE, MUL, DIV.
//   IDLE, accept of a single-cycle op (0-9, 14-15): result registered at that edge,
//    out_valid = 1 the next cycle.
//   IDLE, accept of op 10/11: go to MUL. Shift-add, one multiplier bit per cycle, WIDTH cycles.
//    On the last iteration, register result and return to IDLE. out_valid rises WIDTH+1 cycles
//    after accept.
//   IDLE, accept of op 12/13: go to DIV. Restoring division, one quotient bit per cycle,
//    same latency as MUL.
//    y == 0: quotient = all ones, remainder = x, v = 1, still WIDTH+1 cycle latency.
//  Operands and opcode are latched at accept. Input changes during MUL/DIV have no effect.
//  Output register holds stable while out_valid & ~out_ready.
//   out_valid clears on out_ready unless a new single-cycle result loads in the same edge.
//  Simultaneous pop and push in IDLE: old result consumed and new request accepted in one edge.
//   For a single-cycle op, out_valid stays 1 with the new value.
//  Reserved ops 14/15: alu_out = 0, v = 1, c = 0, z = 1.
// CONFIGURATION
//  CRP16_ALU_DIV_EN defined: DIV state and divider datapath present; ops 12/13 as above.
//  Not defined: no divider logic. Ops 12/13 behave as reserved ops
//   (single cycle, alu_out = 0, v = 1, z = 1).
// TESTING (WIDTH = 16)
//  1. Reset, then release -> out_valid = 0, alu_out = 0, vcnz = 0000, in_ready = 1.
//  2. ADD 7FFF+0001 -> 8000, v=1 c=0 n=1 z=0, out_valid 1 cycle after accept.
//     Then ADC FFFF+0001 -> 0000, c=1 z=1. Then ADC 0000+0000 -> 0001.
//  3. MUL 0100*0100 -> 0000, c=v=1, z=1, out_valid exactly 17 cycles after accept.
//     MULH 0100*0100 -> 0001. MUL FFFF*FFFF -> 0001, c=v=1.
//  4. With DIV_EN: DIVU 0064/0007 -> 000E; REMU -> 0002; DIVU 0005/0000 -> FFFF, v=1.
//     Without DIV_EN: DIVU 0064/0007 -> 0000, v=1, 1-cycle latency.
//  5. Hold out_ready = 0 for 5 cycles after a result -> alu_out/flags stable, in_ready = 0.
//     Then out_ready = 1 with a queued XOR F0F0^0FF0 -> FF00 loads the same edge,
//     out_valid never drops.
//  6. Assert resetn = 0 on cycle 5 of a MUL -> immediate IDLE, out_valid = 0,
//     no stale result after release. Next SUB 0000-0001 -> FFFF, c=0 n=1.

Source files
------------

// File: rtl/crp16_alu_seq.sv
// Multi-cycle CRP16 ALU: single-cycle logic/shift/add ops, iterative shift-add multiply and
// restoring divide. Define CRP16_ALU_DIV_EN to build the divider (ops 12/13); otherwise they act as reserved.
module crp16_alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [3:0]       select,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic             v,
  output logic             c,
  output logic             n,
  output logic             z
);
  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q;
  logic             vld_q, v_q, c_q, n_q, z_q;
  logic [WIDTH-1:0] res_q;
  logic [SHW-1:0]   cnt_q;

  // iteration datapath: acc = product high half / partial remainder, lo = multiplier / dividend->quotient
  logic [WIDTH-1:0] acc_q, lo_q, opb_q;
  logic             hi_sel_q;

  logic             accept, is_mul;
  logic signed [WIDTH-1:0] xs;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] b_eff;
  logic             cin;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] sc_res;
  logic             sc_v, sc_c;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_acc_nx, mul_lo_nx;
  logic [WIDTH-1:0] ld_res;
  logic             ld_v, ld_c;

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  assign in_ready = (state_q == S_IDLE) && (!vld_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (select == 4'd10) || (select == 4'd11);
  assign xs       = x;
  assign shamt    = y[SHW-1:0];

`ifdef CRP16_ALU_DIV_EN
  logic             is_div;
  logic [WIDTH:0]   div_sh;
  logic             div_ge;
  logic [WIDTH-1:0] div_dif, div_acc_nx, div_lo_nx;

  assign is_div = (select == 4'd12) || (select == 4'd13);

  // one restoring step; the partial remainder never needs more than WIDTH+1 bits
  always_comb begin
    div_sh     = {acc_q, lo_q[WIDTH-1]};
    div_ge     = div_sh >= {1'b0, opb_q};
    div_dif    = div_sh[WIDTH-1:0] - opb_q;
    div_acc_nx = div_ge ? div_dif : div_sh[WIDTH-1:0];
    div_lo_nx  = {lo_q[WIDTH-2:0], div_ge};
  end
`endif

  always_comb begin
    b_eff = y;
    cin   = 1'b0;
    case (select)
      4'd7:    begin b_eff = ~y; cin = 1'b1; end
      4'd8:    cin = c_q;
      4'd9:    begin b_eff = ~y; cin = c_q; end
      default: ;
    endcase
    add_sum = {1'b0, x} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};

    sc_res = '0;
    sc_v   = 1'b0;
    sc_c   = 1'b0;
    case (select)
      4'd0: sc_res = x >> shamt;
      4'd1: sc_res = $unsigned(xs >>> shamt);
      4'd2: sc_res = x << shamt;
      4'd3: sc_res = x & y;
      4'd4: sc_res = x | y;
      4'd5: sc_res = x ^ y;
      4'd6, 4'd7, 4'd8, 4'd9: begin
        sc_res = add_sum[WIDTH-1:0];
        sc_c   = add_sum[WIDTH];
        sc_v   = add_ovf(x[WIDTH-1], b_eff[WIDTH-1], add_sum[WIDTH-1]);
      end
      default: sc_v = 1'b1;
    endcase
  end

  always_comb begin
    mul_sum    = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
    mul_acc_nx = mul_sum[WIDTH:1];
    mul_lo_nx  = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  always_comb begin
    ld_res = sc_res;
    ld_v   = sc_v;
    ld_c   = sc_c;
    if (state_q == S_MUL) begin
      ld_res = hi_sel_q ? mul_acc_nx : mul_lo_nx;
      ld_v   = hi_sel_q ? 1'b0 : |mul_acc_nx;
      ld_c   = hi_sel_q ? 1'b0 : |mul_acc_nx;
    end
`ifdef CRP16_ALU_DIV_EN
    else if (state_q == S_DIV) begin
      ld_res = hi_sel_q ? div_acc_nx : div_lo_nx;
      ld_v   = ~|opb_q;
      ld_c   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      vld_q   <= 1'b0;
      res_q   <= '0;
      v_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (vld_q && out_ready) vld_q <= 1'b0;
          if (accept) begin
            cnt_q <= '0;
            if (is_mul) begin
              state_q <= S_MUL;
            end
`ifdef CRP16_ALU_DIV_EN
            else if (is_div) begin
              state_q <= S_DIV;
            end
`endif
            else begin
              vld_q <= 1'b1;
              res_q <= ld_res;
              v_q   <= ld_v;
              c_q   <= ld_c;
              n_q   <= ld_res[WIDTH-1];
              z_q   <= ~|ld_res;
            end
          end
        end
        S_MUL, S_DIV: begin
          cnt_q <= cnt_q + SHW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q <= S_IDLE;
            vld_q   <= 1'b1;
            res_q   <= ld_res;
            v_q     <= ld_v;
            c_q     <= ld_c;
            n_q     <= ld_res[WIDTH-1];
            z_q     <= ~|ld_res;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (accept && is_mul) begin
      acc_q    <= '0;
      lo_q     <= y;
      opb_q    <= x;
      hi_sel_q <= select[0];
    end
`ifdef CRP16_ALU_DIV_EN
    else if (accept && is_div) begin
      acc_q    <= '0;
      lo_q     <= x;
      opb_q    <= y;
      hi_sel_q <= select[0];
    end else if (state_q == S_DIV) begin
      acc_q <= div_acc_nx;
      lo_q  <= div_lo_nx;
    end
`endif
    else if (state_q == S_MUL) begin
      acc_q <= mul_acc_nx;
      lo_q  <= mul_lo_nx;
    end
  end

  assign out_valid = vld_q;
  assign alu_out   = res_q;
  assign v         = v_q;
  assign c         = c_q;
  assign n         = n_q;
  assign z         = z_q;

endmodule

// File: tb/tb_crp16_alu_seq.sv
// Self-checking bench for crp16_alu_seq (WIDTH=16): directed cases plus random ops vs. an arithmetic model.
module tb_crp16_alu_seq;
  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] x, y;
  logic [3:0]  select;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] alu_out;
  logic        v, c, n, z;

  int          n_err = 0;
  int          n_chk = 0;
  logic        m_c = 1'b0;
  logic [15:0] obs_res;
  logic [3:0]  obs_f;
  int          obs_lat;

  crp16_alu_seq #(.WIDTH(16)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .select(select), .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .v(v), .c(c), .n(n), .z(z)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_chk);
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: plain integer arithmetic on the architectural rules.
  function automatic void model(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b,
                                input logic cin, output logic [15:0] r, output logic ov,
                                output logic cy, output int lat);
    int             sa, sb, ss, k;
    int unsigned    us;
    longint unsigned p;
    logic           sub;
    r = 16'h0; ov = 1'b0; cy = 1'b0; lat = 1;
    sa = $signed(a);
    p  = longint'(a) * longint'(b);
    case (sel)
      4'd0: r = a >> b[3:0];
      4'd1: r = 16'(sa >>> b[3:0]);
      4'd2: r = a << b[3:0];
      4'd3: r = a & b;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      4'd6, 4'd7, 4'd8, 4'd9: begin
        sub = (sel == 4'd7) || (sel == 4'd9);
        k   = (sel == 4'd6) ? 0 : (sel == 4'd7) ? 1 : int'(cin);
        sb  = $signed(b);
        if (sub) sb = -sb - 1;
        ss  = sa + sb + k;
        ov  = (ss > 32767) || (ss < -32768);
        us  = 32'(a) + (sub ? 32'(16'hFFFF - b) : 32'(b)) + 32'(k);
        cy  = us >= 32'd65536;
        r   = 16'(us);
      end
      4'd10: begin r = 16'(p); ov = (p >> 16) != 0; cy = ov; lat = 17; end
      4'd11: begin r = 16'(p >> 16); lat = 17; end
`ifdef CRP16_ALU_DIV_EN
      4'd12, 4'd13: begin
        lat = 17;
        if (b == 16'h0) begin
          ov = 1'b1;
          r  = (sel == 4'd12) ? 16'hFFFF : a;
        end else begin
          r  = (sel == 4'd12) ? a / b : a % b;
        end
      end
`endif
      default: ov = 1'b1;
    endcase
  endfunction

  task automatic run_op(input logic [3:0] sel, input logic [15:0] a, input logic [15:0] b);
    logic [15:0] er;
    logic        ev, ec;
    int          elat, lat;
    model(sel, a, b, m_c, er, ev, ec, elat);
    check($sformatf("op%0d_rdy", sel), 32'(in_ready), 32'd1);
    in_valid = 1'b1; select = sel; x = a; y = b;
    @(posedge clk); #1;
    in_valid = 1'b0; select = 4'($urandom); x = 16'($urandom); y = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("op%0d_lat", sel), 32'(lat), 32'(elat));
    check($sformatf("op%0d_res a=%h b=%h", sel, a, b), 32'(alu_out), 32'(er));
    check($sformatf("op%0d_vcnz a=%h b=%h", sel, a, b), 32'({v, c, n, z}),
          32'({ev, ec, er[15], er == 16'h0}));
    m_c = ec; obs_res = alu_out; obs_f = {v, c, n, z}; obs_lat = lat;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check($sformatf("op%0d_pop", sel), 32'(out_valid), 32'd0);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 5))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      3:       return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] er;
    logic        ev, ec;
    int          elat;
    resetn = 1'b0; in_valid = 1'b0; out_ready = 1'b0; x = '0; y = '0; select = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    @(posedge clk); #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_out", 32'(alu_out), 32'd0);
    check("rst_vcnz", 32'({v, c, n, z}), 32'd0);
    check("rst_ready", 32'(in_ready), 32'd1);

    // add / carry chain
    run_op(4'd6, 16'h7FFF, 16'h0001);
    check("add_res", 32'(obs_res), 32'h8000);
    check("add_vcnz", 32'(obs_f), 32'b1010);
    check("add_lat", 32'(obs_lat), 32'd1);
    run_op(4'd8, 16'hFFFF, 16'h0001);
    check("adc1_res", 32'(obs_res), 32'h0000);
    check("adc1_vcnz", 32'(obs_f), 32'b0101);
    run_op(4'd8, 16'h0000, 16'h0000);
    check("adc2_res", 32'(obs_res), 32'h0001);

    // multiply
    run_op(4'd10, 16'h0100, 16'h0100);
    check("mul_res", 32'(obs_res), 32'h0000);
    check("mul_vcnz", 32'(obs_f), 32'b1101);
    check("mul_lat", 32'(obs_lat), 32'd17);
    run_op(4'd11, 16'h0100, 16'h0100);
    check("mulh_res", 32'(obs_res), 32'h0001);
    run_op(4'd10, 16'hFFFF, 16'hFFFF);
    check("mulff_res", 32'(obs_res), 32'h0001);
    check("mulff_vcnz", 32'(obs_f), 32'b1100);

    // divide
`ifdef CRP16_ALU_DIV_EN
    run_op(4'd12, 16'h0064, 16'h0007);
    check("divu_res", 32'(obs_res), 32'h000E);
    run_op(4'd13, 16'h0064, 16'h0007);
    check("remu_res", 32'(obs_res), 32'h0002);
    run_op(4'd12, 16'h0005, 16'h0000);
    check("div0_res", 32'(obs_res), 32'hFFFF);
    check("div0_vcnz", 32'(obs_f), 32'b1010);
    run_op(4'd13, 16'h0005, 16'h0000);
    check("rem0_res", 32'(obs_res), 32'h0005);
`else
    run_op(4'd12, 16'h0064, 16'h0007);
    check("divu_res", 32'(obs_res), 32'h0000);
    check("divu_vcnz", 32'(obs_f), 32'b1001);
    check("divu_lat", 32'(obs_lat), 32'd1);
`endif
    run_op(4'd15, 16'h1234, 16'h5678);
    check("rsv_vcnz", 32'(obs_f), 32'b1001);

    // backpressure: result held, queued XOR loads on the pop edge
    model(4'd6, 16'h1234, 16'hF111, m_c, er, ev, ec, elat);
    in_valid = 1'b1; select = 4'd6; x = 16'h1234; y = 16'hF111;
    @(posedge clk); #1;
    check("bp_valid", 32'(out_valid), 32'd1);
    select = 4'd5; x = 16'hF0F0; y = 16'h0FF0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_hold_res", 32'(alu_out), 32'(er));
      check("bp_hold_vcnz", 32'({v, c, n, z}), 32'({ev, ec, er[15], er == 16'h0}));
      check("bp_hold_rdy", 32'(in_ready), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    #1 check("bp_rdy_on_pop", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    check("bp_swap_valid", 32'(out_valid), 32'd1);
    check("bp_swap_res", 32'(alu_out), 32'hFF00);
    check("bp_swap_vcnz", 32'({v, c, n, z}), 32'b0010);
    m_c = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_pop", 32'(out_valid), 32'd0);

    // reset in the middle of a multiply
    in_valid = 1'b1; select = 4'd10; x = 16'h1234; y = 16'h5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 resetn = 1'b0;
    #1;
    check("mrst_valid", 32'(out_valid), 32'd0);
    check("mrst_out", 32'(alu_out), 32'd0);
    check("mrst_vcnz", 32'({v, c, n, z}), 32'd0);
    check("mrst_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #2 resetn = 1'b1;
    m_c = 1'b0;
    repeat (20) @(posedge clk);
    #1 check("mrst_stale", 32'(out_valid), 32'd0);
    run_op(4'd7, 16'h0000, 16'h0001);
    check("sub_res", 32'(obs_res), 32'hFFFF);
    check("sub_vcnz", 32'(obs_f), 32'b0010);

    // random ops against the model
    for (int i = 0; i < 80; i++) begin
      run_op(4'($urandom_range(0, 15)), pick(), pick());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
